bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-clock block-RAM (separate read and write ports, 16-bit words, one-cycle registered read) between requester A and requester B. Each requester uses a valid/ready request channel and receives tagged read responses. A read and a write from different requesters issue in the same cycle. Same-type requests are resolved round-robin. The block sits directly in front of the BRAM instance and drives all of its control, address and data inputs.

---
 rtl/bram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester read/write arbiter in front of a single-clock BRAM
//
// Purpose:
//   Shares one BRAM (separate read and write ports, 16-bit words, one-cycle
//   registered read) between requesters A and B. A read and a write from
//   different requesters issue in the same cycle. Same-type contention is
//   resolved round-robin through a priority flop that points at the last loser.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   {a,b}_req_valid/ready         request handshake (ready is combinational)
//   {a,b}_req_we/addr/wdata       request op (1 = write), word address, write data
//   {a,b}_rsp_valid/rdata         tagged read response, one cycle after accept
//   mem_rd_en/mem_rd_addr         BRAM read port
//   mem_wr_en/mem_wr_addr         BRAM write port
//   mem_data_in/mem_data_out      BRAM write data / registered read data
//   conflict_count                saturating count of same-type contention cycles

module bram_port_arbiter #(
  parameter int NUM_BLOCKS = 16,
  parameter int ADDR_W     = 8 + $clog2(NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [15:0]       a_req_wdata,
  output logic              a_rsp_valid,
  output logic [15:0]       a_rsp_rdata,

  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [15:0]       b_req_wdata,
  output logic              b_rsp_valid,
  output logic [15:0]       b_rsp_rdata,

  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [15:0]       mem_data_in,
  input  logic [15:0]       mem_data_out,

  output logic [15:0]       conflict_count
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  req_id_e     prio_q, prio_d;
  req_id_e     rd_tag_q, rd_tag_d;
  logic        rd_vld_q, rd_vld_d;
  logic [15:0] conflict_count_q, conflict_count_d;

  logic a_rd, a_wr, b_rd, b_wr;
  logic contend;
  logic a_gnt, b_gnt;
  logic b_rd_sel, b_wr_sel;

  always_comb begin
    a_rd = a_req_valid & ~a_req_we;
    a_wr = a_req_valid &  a_req_we;
    b_rd = b_req_valid & ~b_req_we;
    b_wr = b_req_valid &  b_req_we;

    // Contention only when both want the same port; a read and a write
    // from different requesters never block each other.
    contend = (a_rd & b_rd) | (a_wr & b_wr);

    // Reset forces every grant low so nothing reaches the BRAM while rst is high.
    a_gnt = ~rst & a_req_valid & ~(contend & (prio_q == REQ_B));
    b_gnt = ~rst & b_req_valid & ~(contend & (prio_q == REQ_A));

    b_rd_sel = b_gnt & ~b_req_we;
    b_wr_sel = b_gnt &  b_req_we;

    mem_rd_en   = (a_gnt & ~a_req_we) | b_rd_sel;
    mem_rd_addr = b_rd_sel ? b_req_addr : a_req_addr;
    mem_wr_en   = (a_gnt & a_req_we) | b_wr_sel;
    mem_wr_addr = b_wr_sel ? b_req_addr : a_req_addr;
    mem_data_in = b_wr_sel ? b_req_wdata : a_req_wdata;

    // Priority moves to the loser, so sustained contention alternates grants.
    prio_d = prio_q;
    if (contend) begin
      prio_d = (prio_q == REQ_A) ? REQ_B : REQ_A;
    end

    conflict_count_d = conflict_count_q;
    if (contend && (conflict_count_q != 16'hFFFF)) begin
      conflict_count_d = conflict_count_q + 16'd1;
    end

    // Tag the read issued this cycle so its data returns to the right owner.
    rd_vld_d = mem_rd_en;
    rd_tag_d = b_rd_sel ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q           <= REQ_A;
      rd_tag_q         <= REQ_A;
      rd_vld_q         <= 1'b0;
      conflict_count_q <= 16'd0;
    end else begin
      prio_q           <= prio_d;
      rd_tag_q         <= rd_tag_d;
      rd_vld_q         <= rd_vld_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign a_req_ready    = a_gnt;
  assign b_req_ready    = b_gnt;
  assign a_rsp_valid    = rd_vld_q & (rd_tag_q == REQ_A);
  assign b_rsp_valid    = rd_vld_q & (rd_tag_q == REQ_B);
  assign a_rsp_rdata    = mem_data_out;
  assign b_rsp_rdata    = mem_data_out;
  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed scoreboard bench for bram_port_arbiter

module tb_bram_port_arbiter;

  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [15:0]   a_req_wdata;
  logic          a_rsp_valid;
  logic [15:0]   a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr;
  logic [15:0]   b_req_wdata;
  logic          b_rsp_valid;
  logic [15:0]   b_rsp_rdata;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [15:0]   mem_data_in, mem_data_out;
  logic [15:0]   conflict_count;

  bram_port_arbiter #(.NUM_BLOCKS(16)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .conflict_count(conflict_count)
  );

  typedef struct {
    bit          tag;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [0:4095];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] last_a_rdata;

  logic          s_ga, s_gb, s_a_ready, s_b_ready, s_rd_en, s_wr_en;
  logic [AW-1:0] s_rd_addr, s_wr_addr;
  logic [15:0]   s_din, s_cc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // BRAM model: port values latched at the falling edge, applied at the rising
  // edge; read returns the pre-write word on a same-address collision.
  initial begin
    logic [15:0]   bram [0:4095];
    logic          l_rd, l_wr;
    logic [AW-1:0] l_ra, l_wa;
    logic [15:0]   l_din, rd_word;
    for (int i = 0; i < 4096; i++) bram[i] = 16'(i) ^ 16'h5A5A;
    mem_data_out = 16'h0;
    forever begin
      @(negedge clk);
      l_rd = mem_rd_en; l_wr = mem_wr_en; l_ra = mem_rd_addr;
      l_wa = mem_wr_addr; l_din = mem_data_in;
      @(posedge clk);
      rd_word = bram[l_ra];
      if (l_wr) bram[l_wa] = l_din;
      if (l_rd) mem_data_out <= rd_word;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard when an entry falls due, otherwise
  // requires both response valids to be quiet.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.tag == 1'b0) begin
          chk("rsp_a_valid", a_rsp_valid, 1);
          chk("rsp_b_quiet", b_rsp_valid, 0);
          chk("rsp_a_data", a_rsp_rdata, e.data);
          last_a_rdata = a_rsp_rdata;
        end else begin
          chk("rsp_b_valid", b_rsp_valid, 1);
          chk("rsp_a_quiet", a_rsp_valid, 0);
          chk("rsp_b_data", b_rsp_rdata, e.data);
        end
      end else begin
        chk("rsp_idle", {a_rsp_valid, b_rsp_valid}, 0);
      end
    end
  end

  task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [15:0] wd);
    a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [15:0] wd);
    b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = wd;
  endtask

  // One clock: sample at the falling edge, record accepted transfers into the
  // scoreboard and reference memory, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    s_a_ready = a_req_ready; s_b_ready = b_req_ready;
    s_ga = a_req_valid & a_req_ready;
    s_gb = b_req_valid & b_req_ready;
    s_rd_en = mem_rd_en; s_wr_en = mem_wr_en;
    s_rd_addr = mem_rd_addr; s_wr_addr = mem_wr_addr;
    s_din = mem_data_in; s_cc = conflict_count;
    if (s_ga && !a_req_we) sb.push_back('{1'b0, ref_mem[a_req_addr], cyc + 1});
    if (s_gb && !b_req_we) sb.push_back('{1'b1, ref_mem[b_req_addr], cyc + 1});
    if (s_ga && a_req_we) ref_mem[a_req_addr] = a_req_wdata;
    if (s_gb && b_req_we) ref_mem[b_req_addr] = b_req_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] aa, ba;
    logic [15:0]   ad, bd;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i) ^ 16'h5A5A;

    // Reset with both requesters asking.
    rst = 1'b1;
    set_a(1, 0, 12'h000, 16'h0);
    set_b(1, 1, 12'h001, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_b_ready", b_req_ready, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    @(posedge clk); #1;
    set_a(0, 0, 12'h000, 16'h0);
    set_b(0, 0, 12'h000, 16'h0);
    rst = 1'b0;
    step();
    chk("post_rst_rd_en", s_rd_en, 0);
    chk("post_rst_wr_en", s_wr_en, 0);
    chk("post_rst_cc", s_cc, 0);
    chk("post_rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);

    // A writes then reads back.
    set_a(1, 1, 12'h010, 16'h1234);
    step();
    chk("a_wr_accept", s_ga, 1);
    chk("a_wr_en", s_wr_en, 1);
    chk("a_wr_addr", s_wr_addr, 12'h010);
    chk("a_wr_din", s_din, 16'h1234);
    set_a(1, 0, 12'h010, 16'h0);
    step();
    chk("a_rd_accept", s_ga, 1);
    chk("a_rd_en", s_rd_en, 1);
    chk("a_rd_addr", s_rd_addr, 12'h010);
    set_a(0, 0, 12'h000, 16'h0);
    step();
    chk("a_readback", last_a_rdata, 16'h1234);

    // Simultaneous read (A) and write (B) to the same address.
    set_a(1, 0, 12'h020, 16'h0);
    set_b(1, 1, 12'h020, 16'hBEEF);
    step();
    chk("mix_a_ready", s_a_ready, 1);
    chk("mix_b_ready", s_b_ready, 1);
    chk("mix_rd_en", s_rd_en, 1);
    chk("mix_wr_en", s_wr_en, 1);
    chk("mix_din", s_din, 16'hBEEF);
    set_b(0, 0, 12'h000, 16'h0);
    step();
    chk("mix_old_word", last_a_rdata, 16'h5A7A);
    set_a(0, 0, 12'h000, 16'h0);
    step();
    chk("mix_new_word", last_a_rdata, 16'hBEEF);
    chk("mix_cc", s_cc, 0);

    // Sustained read contention: grants alternate starting with A.
    aa = 12'h030; ba = 12'h040;
    for (int i = 0; i < 6; i++) begin
      set_a(1, 0, aa, 16'h0);
      set_b(1, 0, ba, 16'h0);
      step();
      chk($sformatf("rd_rr_%0d", i), {s_ga, s_gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (s_ga) aa = aa + 12'd1;
      if (s_gb) ba = ba + 12'd1;
    end
    set_a(0, 0, 12'h000, 16'h0);
    set_b(0, 0, 12'h000, 16'h0);
    step();
    chk("rd_rr_cc", s_cc, 6);

    // Write contention on one address: last grant (B's second write) wins.
    ad = 16'hA000; bd = 16'hB000;
    for (int i = 0; i < 4; i++) begin
      set_a(1, 1, 12'h100, ad);
      set_b(1, 1, 12'h100, bd);
      step();
      chk($sformatf("wr_rr_%0d", i), {s_ga, s_gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (s_ga) ad = ad + 16'd1;
      if (s_gb) bd = bd + 16'd1;
    end
    set_b(0, 0, 12'h000, 16'h0);
    set_a(1, 0, 12'h100, 16'h0);
    step();
    chk("wr_rr_cc", s_cc, 10);
    set_a(0, 0, 12'h000, 16'h0);
    step();
    chk("wr_rr_final", last_a_rdata, 16'hB001);

    // Drive the counter to 0xFFFE, then across saturation.
    set_a(1, 1, 12'h101, 16'h1111);
    set_b(1, 1, 12'h101, 16'h2222);
    for (int i = 0; i < 16'hFFFE - 10; i++) step();
    set_a(0, 0, 12'h000, 16'h0);
    set_b(0, 0, 12'h000, 16'h0);
    step();
    chk("cc_preload", s_cc, 16'hFFFE);
    set_a(1, 1, 12'h101, 16'h1111);
    set_b(1, 1, 12'h101, 16'h2222);
    for (int i = 0; i < 3; i++) step();
    set_a(0, 0, 12'h000, 16'h0);
    set_b(0, 0, 12'h000, 16'h0);
    step();
    chk("cc_saturate", s_cc, 16'hFFFF);
    set_a(1, 1, 12'h101, 16'h1111);
    set_b(1, 1, 12'h101, 16'h2222);
    step();
    set_a(0, 0, 12'h000, 16'h0);
    set_b(0, 0, 12'h000, 16'h0);
    step();
    chk("cc_hold", s_cc, 16'hFFFF);

    // Leave priority at B, then reset right after a B read accept.
    set_a(1, 0, 12'h060, 16'h0);
    set_b(1, 0, 12'h061, 16'h0);
    step();
    chk("pre_rst_grant", {s_ga, s_gb}, 2'b10);
    set_a(0, 0, 12'h000, 16'h0);
    set_b(1, 0, 12'h050, 16'h0);
    step();
    chk("pre_rst_b_accept", s_gb, 1);
    rst = 1'b1;
    sb.delete();
    set_a(1, 0, 12'h070, 16'h0);
    set_b(1, 0, 12'h071, 16'h0);
    @(negedge clk);
    chk("rst_b_rsp", b_rsp_valid, 0);
    chk("rst_a_rsp", a_rsp_valid, 0);
    chk("rst_mid_a_ready", a_req_ready, 0);
    chk("rst_mid_b_ready", b_req_ready, 0);
    chk("rst_mid_rd_en", mem_rd_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("post_rst2_cc", s_cc, 0);
    chk("post_rst2_grant", {s_ga, s_gb}, 2'b10);
    set_a(0, 0, 12'h000, 16'h0);
    set_b(0, 0, 12'h000, 16'h0);
    step();
    step();
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
